// File: rtl/stc_pkg.sv
// Shared types and default widths for the sparse tensor core load sequencer.
package stc_pkg;

  localparam int STC_M       = 16;
  localparam int STC_N       = 16;
  localparam int STC_DW_MEM  = 256;
  localparam int STC_DW_DATA = 16;
  localparam int STC_DW_IDX  = 4;
  localparam int STC_ROW_W   = STC_N * STC_DW_DATA;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_A  = 3'd1,
    ST_LOAD_BC = 3'd2,
    ST_LOAD_CU = 3'd3,
    ST_WAIT_D  = 3'd4
  } stc_seq_state_t;

endpackage

// File: rtl/stc_watchdog.sv
// Loadable down-counter; expired fires on the (TIMEOUT-1)-th consecutive enabled
// cycle after the last clear.
module stc_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT - 2);
  localparam logic [CW-1:0] ZERO     = CW'(0);
  localparam logic [CW-1:0] ONE      = CW'(1);

  logic [CW-1:0] r_cnt;

  // Reload on clear, otherwise count enabled cycles down to zero and hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= LOAD_VAL;
    end else if (clr) begin
      r_cnt <= LOAD_VAL;
    end else if (en && (r_cnt != ZERO)) begin
      r_cnt <= r_cnt - ONE;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign expired = en && (r_cnt == ZERO);

endmodule

// File: rtl/stc_load_sequencer.sv
// Routes a two-lane beat stream into the sparse tensor core's A, B/C and control
// write ports, then collects the M result rows with tags, completion and timeout.
module stc_load_sequencer
  import stc_pkg::*;
#(
  parameter int M       = STC_M,
  parameter int N       = STC_N,
  parameter int DW_MEM  = STC_DW_MEM,
  parameter int DW_DATA = STC_DW_DATA,
  parameter int DW_IDX  = STC_DW_IDX,
  parameter int TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [DW_IDX:0]        n_a_rows,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DW_MEM-1:0]      in_data,
  input  logic [DW_MEM-1:0]      in_aux,
  output logic                   write_a_data_en,
  output logic                   write_a_cidx_en,
  output logic                   write_b,
  output logic                   write_c,
  output logic                   write_cu,
  output logic [DW_MEM-1:0]      A_data_input,
  output logic [DW_MEM-1:0]      A_colidx_input,
  output logic [DW_MEM-1:0]      B_input,
  output logic [DW_MEM-1:0]      cu_input,
  output logic [N*DW_DATA-1:0]   in_c,
  output logic [DW_IDX-1:0]      A_idx,
  output logic [DW_IDX-1:0]      B_row,
  output logic [DW_IDX-1:0]      in_c_row,
  input  logic                   out_valid,
  input  logic [N*DW_DATA-1:0]   out_d,
  output logic                   d_valid,
  output logic [N*DW_DATA-1:0]   d_data,
  output logic [DW_IDX-1:0]      d_row,
  output logic                   d_last,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int ROW_W = N * DW_DATA;
  localparam int CNT_W = DW_IDX + 1;
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_M_LAST = CNT_W'(M - 1);

  stc_seq_state_t r_state;
  logic [CNT_W-1:0]  r_n_a;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_row;
  logic              r_in_ready;
  logic              r_busy;
  logic              r_err;
  logic              r_done;
  logic              r_wr_a;
  logic              r_wr_bc;
  logic              r_wr_cu;
  logic [DW_MEM-1:0] r_a_data;
  logic [DW_MEM-1:0] r_a_cidx;
  logic [DW_MEM-1:0] r_b_data;
  logic [DW_MEM-1:0] r_cu_data;
  logic [ROW_W-1:0]  r_c_data;
  logic [DW_IDX-1:0] r_a_idx;
  logic [DW_IDX-1:0] r_bc_row;
  logic              r_d_valid;
  logic [ROW_W-1:0]  r_d_data;
  logic [DW_IDX-1:0] r_d_row;

  logic w_accept;
  logic w_wd_clr;
  logic w_wd_en;
  logic w_wd_expired;

  assign w_accept = in_valid && r_in_ready;
  // Watchdog restarts when WAIT_D is entered (CU beat accepted) and on each result row.
  assign w_wd_clr = ((r_state == ST_LOAD_CU) && w_accept) ||
                    ((r_state == ST_WAIT_D) && out_valid);
  assign w_wd_en  = (r_state == ST_WAIT_D) && !out_valid;

  stc_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (reset),
    .clr     (w_wd_clr),
    .en      (w_wd_en),
    .expired (w_wd_expired)
  );

  // Phase FSM with beat routing, result-row tagging and status; strobes are one-cycle pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_n_a      <= CNT_ZERO;
      r_cnt      <= CNT_ZERO;
      r_row      <= CNT_ZERO;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_done     <= 1'b0;
      r_wr_a     <= 1'b0;
      r_wr_bc    <= 1'b0;
      r_wr_cu    <= 1'b0;
      r_a_data   <= {DW_MEM{1'b0}};
      r_a_cidx   <= {DW_MEM{1'b0}};
      r_b_data   <= {DW_MEM{1'b0}};
      r_cu_data  <= {DW_MEM{1'b0}};
      r_c_data   <= {ROW_W{1'b0}};
      r_a_idx    <= {DW_IDX{1'b0}};
      r_bc_row   <= {DW_IDX{1'b0}};
      r_d_valid  <= 1'b0;
      r_d_data   <= {ROW_W{1'b0}};
      r_d_row    <= {DW_IDX{1'b0}};
    end else begin
      r_wr_a    <= 1'b0;
      r_wr_bc   <= 1'b0;
      r_wr_cu   <= 1'b0;
      r_d_valid <= 1'b0;
      r_done    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_n_a      <= n_a_rows;
            r_err      <= 1'b0;
            r_cnt      <= CNT_ZERO;
            r_busy     <= 1'b1;
            r_in_ready <= 1'b1;
            r_state    <= (n_a_rows != CNT_ZERO) ? ST_LOAD_A : ST_LOAD_BC;
          end
        end
        ST_LOAD_A: begin
          if (w_accept) begin
            r_wr_a   <= 1'b1;
            r_a_data <= in_data;
            r_a_cidx <= in_aux;
            r_a_idx  <= r_cnt[DW_IDX-1:0];
            if ((r_cnt + CNT_ONE) == r_n_a) begin
              r_cnt   <= CNT_ZERO;
              r_state <= ST_LOAD_BC;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
        end
        ST_LOAD_BC: begin
          if (w_accept) begin
            r_wr_bc  <= 1'b1;
            r_b_data <= in_data;
            r_c_data <= in_aux[ROW_W-1:0];
            r_bc_row <= r_cnt[DW_IDX-1:0];
            if (r_cnt == CNT_M_LAST) begin
              r_cnt   <= CNT_ZERO;
              r_state <= ST_LOAD_CU;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
        end
        ST_LOAD_CU: begin
          if (w_accept) begin
            r_wr_cu    <= 1'b1;
            r_cu_data  <= in_data;
            r_row      <= CNT_ZERO;
            r_in_ready <= 1'b0;
            r_state    <= ST_WAIT_D;
          end
        end
        ST_WAIT_D: begin
          if (out_valid) begin
            r_d_valid <= 1'b1;
            r_d_data  <= out_d;
            r_d_row   <= r_row[DW_IDX-1:0];
            r_row     <= r_row + CNT_ONE;
            if (r_row == CNT_M_LAST) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end
          end else if (w_wd_expired) begin
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready        = r_in_ready;
  assign write_a_data_en = r_wr_a;
  assign write_a_cidx_en = r_wr_a;
  assign write_b         = r_wr_bc;
  assign write_c         = r_wr_bc;
  assign write_cu        = r_wr_cu;
  assign A_data_input    = r_a_data;
  assign A_colidx_input  = r_a_cidx;
  assign B_input         = r_b_data;
  assign cu_input        = r_cu_data;
  assign in_c            = r_c_data;
  assign A_idx           = r_a_idx;
  assign B_row           = r_bc_row;
  assign in_c_row        = r_bc_row;
  assign d_valid         = r_d_valid;
  assign d_data          = r_d_data;
  assign d_row           = r_d_row;
  assign d_last          = r_done;
  assign done            = r_done;
  assign busy            = r_busy;
  assign err             = r_err;

endmodule

// File: tb/tb_stc_load_sequencer.sv
// Scoreboard bench for stc_load_sequencer with a small core model driving result rows.
module tb_stc_load_sequencer;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [4:0]   n_a_rows;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] in_data;
  logic [255:0] in_aux;
  logic         write_a_data_en, write_a_cidx_en, write_b, write_c, write_cu;
  logic [255:0] A_data_input, A_colidx_input, B_input, cu_input, in_c;
  logic [3:0]   A_idx, B_row, in_c_row;
  logic         out_valid;
  logic [255:0] out_d;
  logic         d_valid;
  logic [255:0] d_data;
  logic [3:0]   d_row;
  logic         d_last, busy, done, err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int           kind;
    int           idx;
    logic [255:0] d;
    logic [255:0] a;
  } wexp_t;
  typedef struct {
    int           row;
    logic [255:0] d;
    bit           last;
  } dexp_t;

  wexp_t wq[$];
  dexp_t dq[$];

  always #5 clk = ~clk;

  stc_load_sequencer #(
    .M(16), .N(16), .DW_MEM(256), .DW_DATA(16), .DW_IDX(4), .TIMEOUT(8)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .n_a_rows(n_a_rows),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_aux(in_aux),
    .write_a_data_en(write_a_data_en), .write_a_cidx_en(write_a_cidx_en),
    .write_b(write_b), .write_c(write_c), .write_cu(write_cu),
    .A_data_input(A_data_input), .A_colidx_input(A_colidx_input),
    .B_input(B_input), .cu_input(cu_input), .in_c(in_c),
    .A_idx(A_idx), .B_row(B_row), .in_c_row(in_c_row),
    .out_valid(out_valid), .out_d(out_d),
    .d_valid(d_valid), .d_data(d_data), .d_row(d_row), .d_last(d_last),
    .busy(busy), .done(done), .err(err)
  );

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [255:0] row_pattern(input int r);
    logic [255:0] v;
    for (int j = 0; j < 16; j++) v[j*16 +: 16] = 16'((r << 8) | j);
    return v;
  endfunction

  function automatic int beat_kind(input int b, input int n_a);
    if (b < n_a) return 0;
    else if (b < n_a + 16) return 1;
    else return 2;
  endfunction

  task automatic do_start(input int n_a);
    start = 1'b1;
    n_a_rows = 5'(n_a);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL start_busy_pre: got %b expected 0", busy);
    end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL start_status: busy=%b in_ready=%b err=%b expected 1 1 0", busy, in_ready, err);
    end
    @(posedge clk); #1;
  endtask

  task automatic run_load(input int n_a, input bit toggle, input int stop, output int nb);
    int    beat = 0;
    int    cyc = 0;
    bit    cu_acc = 1'b0;
    bit    had;
    wexp_t e;
    logic [4:0] sv, ev;
    nb = 0;
    while ((beat < stop || wq.size() > 0) && cyc < 300) begin
      if (beat < stop && (!toggle || (cyc % 2) == 0)) begin
        in_valid = 1'b1;
        in_data  = rand256();
        in_aux   = rand256();
      end else begin
        in_valid = 1'b0;
      end
      // Stray start/out_valid during load phases must have no effect.
      start     = toggle && !cu_acc;
      out_valid = toggle && !cu_acc;
      out_d     = row_pattern(99);
      n_a_rows  = 5'd9;
      @(negedge clk);
      sv  = {write_a_data_en, write_a_cidx_en, write_b, write_c, write_cu};
      ev  = 5'b00000;
      had = (wq.size() > 0);
      if (had) begin
        e = wq.pop_front();
        ev = (e.kind == 0) ? 5'b11000 : (e.kind == 1) ? 5'b00110 : 5'b00001;
      end
      checks++;
      if (sv !== ev) begin
        errors++;
        $display("FAIL load_strobes: got %b expected %b at beat %0d", sv, ev, beat);
      end else if (had) begin
        checks++;
        if (e.kind == 0 && (A_data_input !== e.d || A_colidx_input !== e.a || A_idx !== 4'(e.idx))) begin
          errors++;
          $display("FAIL a_write: A_idx=%0d expected %0d or data differs", A_idx, e.idx);
        end else if (e.kind == 1 && (B_input !== e.d || in_c !== e.a || B_row !== 4'(e.idx) || in_c_row !== 4'(e.idx))) begin
          errors++;
          $display("FAIL bc_write: B_row=%0d in_c_row=%0d expected %0d or data differs", B_row, in_c_row, e.idx);
        end else if (e.kind == 2 && cu_input !== e.d) begin
          errors++;
          $display("FAIL cu_write: got %h expected %h", cu_input[31:0], e.d[31:0]);
        end
      end
      if (sv[2] === 1'b1) nb++;
      checks++;
      if (in_ready !== !cu_acc || d_valid !== 1'b0) begin
        errors++;
        $display("FAIL load_status: in_ready=%b expected %b d_valid=%b expected 0", in_ready, !cu_acc, d_valid);
      end
      @(posedge clk);
      if (in_valid) begin
        e.kind = beat_kind(beat, n_a);
        e.idx  = (e.kind == 0) ? beat : beat - n_a;
        e.d    = in_data;
        e.a    = in_aux;
        wq.push_back(e);
        if (e.kind == 2) cu_acc = 1'b1;
        beat++;
      end
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    out_valid = 1'b0;
    if (cyc >= 300) begin
      checks++;
      errors++;
      $display("FAIL load_timeout: got %0d beats expected %0d", beat, stop);
    end
  endtask

  task automatic readout(input int nrows, input int gap);
    int    sent = 0;
    int    cyc = 0;
    int    idle = 0;
    bit    exp_v;
    dexp_t e;
    while ((sent < nrows || dq.size() > 0) && cyc < 400) begin
      if (sent < nrows && idle >= gap) begin
        out_valid = 1'b1;
        out_d = row_pattern(sent);
      end else begin
        out_valid = 1'b0;
      end
      @(negedge clk);
      exp_v = (dq.size() > 0);
      checks++;
      if (d_valid !== exp_v) begin
        errors++;
        $display("FAIL d_valid: got %b expected %b row %0d", d_valid, exp_v, sent);
      end else if (exp_v) begin
        e = dq.pop_front();
        checks++;
        if (d_data !== e.d || d_row !== 4'(e.row) || d_last !== e.last || done !== e.last) begin
          errors++;
          $display("FAIL d_row_data: row=%0d last=%b done=%b expected row=%0d last=%b", d_row, d_last, done, e.row, e.last);
        end
      end else if (done !== 1'b0) begin
        errors++;
        $display("FAIL done_spurious: got %b expected 0", done);
      end
      @(posedge clk);
      if (out_valid) begin
        e.row  = sent;
        e.d    = out_d;
        e.last = (sent == 15);
        dq.push_back(e);
        sent++;
        idle = 0;
      end else begin
        idle++;
      end
      #1;
      cyc++;
    end
    out_valid = 1'b0;
    if (cyc >= 400) begin
      checks++;
      errors++;
      $display("FAIL readout_timeout: got %0d rows expected %0d", sent, nrows);
    end
  endtask

  task automatic expect_idle(input string name);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: busy=%b in_ready=%b done=%b expected 0 0 0", name, busy, in_ready, done);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({write_a_data_en, write_a_cidx_en, write_b, write_c, write_cu, in_ready,
         d_valid, d_last, done, busy, err} !== 11'd0 ||
        (|{A_data_input, A_colidx_input, B_input, cu_input, in_c, A_idx, B_row, in_c_row, d_data, d_row}) !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: busy=%b err=%b in_ready=%b expected all zero", busy, err, in_ready);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    out_valid = 1'b1;
    out_d = row_pattern(7);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (d_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL idle_out_valid: d_valid=%b busy=%b expected 0 0", d_valid, busy);
      end
      @(posedge clk); #1;
    end
    out_valid = 1'b0;
  endtask

  task automatic test_basic();
    int nb;
    do_start(4);
    run_load(4, 1'b0, 21, nb);
    readout(16, 0);
    expect_idle("basic");
  endtask

  task automatic test_na_zero();
    int nb;
    do_start(0);
    run_load(0, 1'b0, 17, nb);
    readout(16, 1);
    expect_idle("na_zero");
  endtask

  task automatic test_toggle();
    int nb;
    do_start(3);
    run_load(3, 1'b1, 20, nb);
    checks++;
    if (nb != 16) begin
      errors++;
      $display("FAIL toggle_b_pulses: got %0d expected 16", nb);
    end
    readout(16, 2);
    expect_idle("toggle");
  endtask

  task automatic test_timeout();
    int nb;
    int k = 1;
    bit got = 1'b0;
    bit sawdone = 1'b0;
    do_start(1);
    run_load(1, 1'b0, 18, nb);
    readout(5, 0);
    while (k < 30) begin
      @(negedge clk);
      if (done !== 1'b0) sawdone = 1'b1;
      if (err === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
      k++;
    end
    checks++;
    if (!got || k != 7) begin
      errors++;
      $display("FAIL timeout_latency: got err after %0d idle cycles expected 7", k);
    end
    checks++;
    if (sawdone || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_status: done_seen=%b busy=%b expected 0 0", sawdone, busy);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got %b expected 1", err);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midjob();
    int nb;
    do_start(0);
    run_load(0, 1'b0, 7, nb);
    in_valid = 1'b1;
    in_data  = rand256();
    in_aux   = rand256();
    @(posedge clk); #1;
    reset = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({write_a_data_en, write_a_cidx_en, write_b, write_c, write_cu} !== 5'd0 ||
        busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midjob_reset: strobes=%b busy=%b in_ready=%b expected 0 0 0",
               {write_a_data_en, write_a_cidx_en, write_b, write_c, write_cu}, busy, in_ready);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    wq.delete();
    do_start(2);
    run_load(2, 1'b0, 19, nb);
    readout(16, 1);
    expect_idle("after_reset");
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    n_a_rows = 5'd0;
    in_valid = 1'b0;
    in_data = 256'd0;
    in_aux = 256'd0;
    out_valid = 1'b0;
    out_d = 256'd0;
    test_reset();
    test_basic();
    test_na_zero();
    test_toggle();
    test_timeout();
    test_reset_midjob();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
